lsu_align: RTL and testbench

Load/store alignment unit between the RV32 core's execute stage and the word-organised data memory. It accepts one byte-addressed load or store per request, using the RV32 funct3 encoding. It converts the request into byte-enabled word accesses on a synchronous-read memory port, and splits accesses that cross a word boundary into two consecutive word accesses. Load data is reassembled, sign- or zero-extended, and returned with a single-cycle response pulse; the core stalls while `req_ready` is low.

---
 rtl/lsu_align.sv | 249 ++++++++++++++++++++++++
 tb/tb_lsu_align.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Load/store alignment unit between the RV32 execute stage and a
//               word-organised synchronous-read data memory. Converts byte
//               addressed B/H/W accesses into byte-enabled word accesses and
//               splits accesses that straddle a word boundary into two.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align #(
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LO   = 3'd1;
    localparam logic [2:0] S_HI   = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [MEM_AW+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       lo_word_q, lo_word_d;

    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    // Address bits above the memory window do not take part in the access.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

    logic idle;
    logic accept;
    assign idle      = (state_q == S_IDLE);
    assign accept    = idle & req_valid;
    assign req_ready = idle;

    // Request fields: straight from the port on the accept cycle, latched otherwise,
    // so the first word access can be registered on the accept edge itself.
    logic              src_we;
    logic [2:0]        src_f3;
    logic [MEM_AW+1:0] src_addr;
    logic [31:0]       src_wdata;
    logic [1:0]        off;
    logic [3:0]        size_m;
    logic [7:0]        be8;
    logic [63:0]       d64;
    logic              split;
    logic              illegal;
    logic [MEM_AW-1:0] wlo;
    logic [MEM_AW-1:0] whi;

    // Derive byte enables, shifted data, word addresses and legality of the request
    always_comb begin
        src_we    = idle ? req_we     : we_q;
        src_f3    = idle ? req_funct3 : funct3_q;
        src_addr  = idle ? req_addr[MEM_AW+1:0] : addr_q;
        src_wdata = idle ? req_wdata  : wdata_q;
        off       = src_addr[1:0];
        case (src_f3[1:0])
            2'b00:   size_m = 4'b0001;
            2'b01:   size_m = 4'b0011;
            default: size_m = 4'b1111;
        endcase
        be8   = {4'b0000, size_m} << off;
        d64   = {32'h0000_0000, src_wdata} << {off, 3'b000};
        split = |be8[7:4];
        wlo   = src_addr[MEM_AW+1:2];
        whi   = wlo + MEM_AW'(1);
        if (src_we) begin
            illegal = src_f3[2] | (src_f3 == 3'b011);
        end else begin
            illegal = (src_f3 == 3'b011) | (src_f3 == 3'b110) | (src_f3 == 3'b111);
        end
    end

    // Reassemble the loaded value from the captured low word and the word on mem_rdata
    logic [31:0] ld_lo;
    logic [31:0] ld_hi;
    logic [63:0] ld_pair;
    logic [31:0] ld_x;
    logic        ld_sign;
    logic [31:0] ld_res;

    always_comb begin
        ld_lo   = split ? lo_word_q : mem_rdata;
        ld_hi   = split ? mem_rdata : 32'h0000_0000;
        ld_pair = {ld_hi, ld_lo};
        ld_x    = 32'(ld_pair >> {off, 3'b000});
        ld_sign = ~src_f3[2];
        case (src_f3[1:0])
            2'b00:   ld_res = {{24{ld_sign & ld_x[7]}},  ld_x[7:0]};
            2'b01:   ld_res = {{16{ld_sign & ld_x[15]}}, ld_x[15:0]};
            default: ld_res = ld_x;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = illegal ? S_RESP : S_LO;
                end
            end
            S_LO: begin
                if (split) begin
                    state_d = S_HI;
                end else begin
                    state_d = src_we ? S_RESP : S_WAIT;
                end
            end
            S_HI:    state_d = src_we ? S_RESP : S_WAIT;
            S_WAIT:  state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: registered outputs are computed for the state being entered
    always_comb begin
        we_d        = accept ? req_we                : we_q;
        funct3_d    = accept ? req_funct3            : funct3_q;
        addr_d      = accept ? req_addr[MEM_AW+1:0]  : addr_q;
        wdata_d     = accept ? req_wdata             : wdata_q;
        lo_word_d   = (state_q == S_HI) ? mem_rdata  : lo_word_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_be_d    = 4'b0000;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = 32'h0000_0000;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_d)
            S_LO: begin
                mem_en_d   = 1'b1;
                mem_addr_d = wlo;
                if (src_we) begin
                    mem_we_d    = 1'b1;
                    mem_be_d    = be8[3:0];
                    mem_wdata_d = d64[31:0];
                end
            end
            S_HI: begin
                mem_en_d   = 1'b1;
                mem_addr_d = whi;
                if (src_we) begin
                    mem_we_d    = 1'b1;
                    mem_be_d    = be8[7:4];
                    mem_wdata_d = d64[63:32];
                end
            end
            S_RESP: begin
                rsp_valid_d = 1'b1;
                if (idle) begin
                    // Only an illegal request goes straight from IDLE to RESP
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'h0000_0000;
                end else begin
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = src_we ? 32'h0000_0000 : ld_res;
                end
            end
            default: begin
            end
        endcase
    end

    // Request latch, captured low word and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= 32'h0000_0000;
            lo_word_q   <= 32'h0000_0000;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0000_0000;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
        end else begin
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            lo_word_q   <= lo_word_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_align
// Description : Self-checking bench for lsu_align. A byte-array reference
//               model predicts responses and memory writes; monitors compare
//               the DUT against queued expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_align;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = 3'b000;
    logic [31:0]   req_addr = 32'h0;
    logic [31:0]   req_wdata = 32'h0;
    logic          req_ready;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 32'h0;

    always #5 clk = ~clk;

    lsu_align #(.MEM_AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Synchronous-read word memory attached to the DUT
    logic [31:0] mem [0:(1<<AW)-1] = '{default: 32'h0};
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int l = 0; l < 4; l++) begin
                    if (mem_be[l]) mem[mem_addr][8*l +: 8] <= mem_wdata[8*l +: 8];
                end
            end
            mem_rdata <= mem[mem_addr];
        end
    end

    // Reference model: flat byte array of the 4 KiB address window
    logic [7:0] ref_mem [0:4095] = '{default: 8'h00};

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
        int          t0;
    } rsp_t;
    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [31:0]   wd;
    } wr_t;

    rsp_t rq[$];
    wr_t  wq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   acc_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int l = 0; l < 4; l++) m[8*l +: 8] = be[l] ? 8'hFF : 8'h00;
        return m;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_mem_en"},    32'(mem_en),    32'h0);
        check({tag, "_mem_we"},    32'(mem_we),    32'h0);
        check({tag, "_mem_be"},    32'(mem_be),    32'h0);
        check({tag, "_mem_addr"},  32'(mem_addr),  32'h0);
        check({tag, "_mem_wdata"}, mem_wdata,      32'h0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_rsp_rdata"}, rsp_rdata,      32'h0);
        check({tag, "_rsp_err"},   32'(rsp_err),   32'h0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'h1);
    endtask

    // Monitor: memory-port behaviour and responses against the queued expectations
    always @(negedge clk) begin
        if (!rst_n) begin
            acc_cnt = 0;
        end else begin
            if (mem_en) begin
                acc_cnt++;
                if (mem_we) begin
                    if (wq.size() == 0) begin
                        check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
                    end else begin
                        wr_t w;
                        w = wq.pop_front();
                        check("wr_addr",  32'(mem_addr), 32'(w.addr));
                        check("wr_be",    32'(mem_be),   32'(w.be));
                        check("wr_wdata", mem_wdata & lane_mask(w.be), w.wd);
                    end
                end else begin
                    check("read_be", 32'(mem_be), 32'h0);
                end
            end else begin
                check("idle_we_be", 32'({mem_we, mem_be}), 32'h0);
                check("idle_wdata", mem_wdata, 32'h0);
            end
            if (rsp_valid) begin
                if (rq.size() == 0) begin
                    check("unexpected_rsp", rsp_rdata, 32'hFFFF_FFFF);
                end else begin
                    rsp_t r;
                    r = rq.pop_front();
                    check("rsp_rdata",   rsp_rdata,            r.rdata);
                    check("rsp_err",     32'(rsp_err),         32'(r.err));
                    check("rsp_latency", 32'(cyc - r.t0 + 1),  32'(r.lat));
                    check("mem_accesses", 32'(acc_cnt),        32'(r.acc));
                end
                acc_cnt = 0;
            end
        end
    end

    // Issue one request at a negedge; computes expectations from the byte model
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input bit abort);
        int            guard;
        int            n;
        int            lane;
        bit            ill;
        bit            split;
        logic [11:0]   a;
        logic [11:0]   ba;
        logic [AW-1:0] w0;
        logic [3:0]    be0, be1;
        logic [31:0]   wd0, wd1, v;
        rsp_t          r;
        wr_t           w;
        guard = 0;
        while (!req_ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check("ready_timeout", 32'(req_ready), 32'h1);
            return;
        end
        a     = addr[11:0];
        n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        ill   = we ? (f3[2] || f3 == 3'd3) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        split = (int'(a[1:0]) + n) > 4;
        w0    = a[11:2];
        be0 = 4'h0; be1 = 4'h0; wd0 = 32'h0; wd1 = 32'h0; v = 32'h0;
        r.t0 = cyc + 1;
        r.err = 1'b0;
        r.rdata = 32'h0;
        if (ill) begin
            r.err = 1'b1;
            r.lat = 1;
            r.acc = 0;
        end else if (we) begin
            for (int i = 0; i < n; i++) begin
                ba   = a + 12'(i);
                lane = int'(ba[1:0]);
                if (ba[11:2] == w0) begin
                    be0[lane] = 1'b1;
                    wd0[8*lane +: 8] = data[8*i +: 8];
                    ref_mem[ba] = data[8*i +: 8];
                end else begin
                    be1[lane] = 1'b1;
                    wd1[8*lane +: 8] = data[8*i +: 8];
                    if (!abort) ref_mem[ba] = data[8*i +: 8];
                end
            end
            w.addr = w0; w.be = be0; w.wd = wd0;
            wq.push_back(w);
            if (split && !abort) begin
                w.addr = w0 + AW'(1); w.be = be1; w.wd = wd1;
                wq.push_back(w);
            end
            r.lat = split ? 3 : 2;
            r.acc = split ? 2 : 1;
        end else begin
            for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a + 12'(i)];
            if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
            if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
            r.rdata = v;
            r.lat = split ? 4 : 3;
            r.acc = split ? 2 : 1;
        end
        if (!abort) rq.push_back(r);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = data;
        @(posedge clk);
        @(negedge clk);
        // While busy, present junk that must be ignored
        req_valid  = abort ? 1'b0 : 1'($urandom_range(0, 1));
        req_we     = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    initial begin
        int guard;
        logic [31:0] ad;
        #1;
        check_reset_vals("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        issue(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);   // SW
        issue(1'b0, 3'b010, 32'h0000_0010, 32'h0,         1'b0);   // LW
        issue(1'b1, 3'b000, 32'h0000_0013, 32'h0000_0080, 1'b0);   // SB
        issue(1'b0, 3'b000, 32'h0000_0013, 32'h0,         1'b0);   // LB
        issue(1'b0, 3'b100, 32'h0000_0013, 32'h0,         1'b0);   // LBU
        issue(1'b1, 3'b010, 32'h0000_000E, 32'h1122_3344, 1'b0);   // split SW
        issue(1'b0, 3'b010, 32'h0000_000E, 32'h0,         1'b0);   // split LW
        issue(1'b1, 3'b001, 32'h0000_0FFF, 32'h0000_A55A, 1'b0);   // SH wrapping
        issue(1'b0, 3'b001, 32'h0000_0FFF, 32'h0,         1'b0);   // LH
        issue(1'b0, 3'b101, 32'h0000_0FFF, 32'h0,         1'b0);   // LHU
        issue(1'b0, 3'b011, 32'h0000_0020, 32'h0,         1'b0);   // illegal load
        issue(1'b1, 3'b100, 32'h0000_0024, 32'h1234_5678, 1'b0);   // illegal store

        // Split store interrupted by reset while in its second access
        issue(1'b1, 3'b010, 32'h0000_000E, 32'hCAFE_F00D, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 32'h1);
        issue(1'b0, 3'b010, 32'h0000_000C, 32'h0, 1'b0);   // word 3 holds new bytes
        issue(1'b0, 3'b010, 32'h0000_0010, 32'h0, 1'b0);   // word 4 unchanged

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) ad = 32'(4088 + $urandom_range(0, 7));
            else                           ad = 32'($urandom_range(0, 63));
            ad = ad | ($urandom & 32'hFFFF_F000);
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ad, $urandom, 1'b0);
        end

        guard = 0;
        while ((rq.size() != 0 || wq.size() != 0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b0;
        check("rsp_queue_drained", 32'(rq.size()), 32'h0);
        check("wr_queue_drained",  32'(wq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
